// File: rtl/priority_interrupt_controller.sv
// Prioritised multi-source interrupt controller: masked, edge/level pending bits feeding an IDLE/ASSERT/SERVICE handshake.
// Latency: request sampled at edge 0 -> pending after edge 0 -> irq_out after edge 1; no backpressure, host paces via irq_ack/irq_eoi.
module priority_interrupt_controller #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic [NUM_SRC-1:0] irq_edge,
    input  logic               irq_ack,
    input  logic               irq_eoi,
    output logic               irq_out,
    output logic [ID_W-1:0]    irq_id,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ASSERT  = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [NUM_SRC-1:0] src_q, src_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               out_q, out_d;
    logic               svc_q, svc_d;

    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr;
    logic [ID_W-1:0]    winner;
    logic               any_elig;
    logic               cur_elig;

    // Descending scan so the lowest eligible index is written last and wins.
    always_comb begin
        eligible = pend_q & irq_mask;
        any_elig = |eligible;
        winner   = '0;
        cur_elig = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = ID_W'(i);
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_q == ID_W'(i)) cur_elig = eligible[i];
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        out_d   = out_q;
        svc_d   = svc_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    state_d = ASSERT;
                    id_d    = winner;
                    out_d   = 1'b1;
                end
            end
            ASSERT: begin
                if (irq_ack) begin
                    state_d = SERVICE;
                    out_d   = 1'b0;
                    svc_d   = 1'b1;
                    for (int i = 0; i < NUM_SRC; i++) begin
                        clr[i] = (id_q == ID_W'(i));
                    end
                end else if (!cur_elig) begin
                    state_d = IDLE;
                    out_d   = 1'b0;
                end
            end
            SERVICE: begin
                if (irq_eoi) begin
                    state_d = IDLE;
                    svc_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = 1'b0;
                svc_d   = 1'b0;
            end
        endcase
    end

    // A fresh edge in the ack cycle re-sets the bit that the ack clears.
    always_comb begin
        src_d  = irq_src;
        pend_d = (irq_edge & ((irq_src & ~src_q) | (pend_q & ~clr)))
               | (~irq_edge & irq_src);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            pend_q  <= '0;
            id_q    <= '0;
            out_q   <= 1'b0;
            svc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            pend_q  <= pend_d;
            id_q    <= id_d;
            out_q   <= out_d;
            svc_q   <= svc_d;
        end
    end

    assign irq_out    = out_q;
    assign irq_id     = id_q;
    assign in_service = svc_q;
    assign pending    = pend_q;

endmodule
